// File: rtl/alu_arbiter.sv
// Two-requester front end that time-shares a single external combinational ALU.
// One transaction is in flight at a time; ties are broken round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic        id_reg;
  logic [31:0] a_reg, b_reg;
  logic [3:0]  op_reg;
  logic [31:0] rsp_result_reg;
  logic        rsp_zero_reg, rsp_err_reg;

  logic        grant;
  logic        accept;
  logic        rsp_done;
  logic        op_ok;
  logic [31:0] a_next, b_next;
  logic [3:0]  op_next;

  // A lone requester always wins; on a tie the one not served last goes first.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last_grant_reg;
  end

  // req_ready is gated by reset_n so nothing is offered while reset is held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = reset_n && (state_reg == IDLE) && req_valid[gi]
                             && (grant == 1'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (id_reg == 1'(gi));
    end
  endgenerate

  assign accept   = |req_ready;
  assign rsp_done = |(rsp_valid & rsp_ready);

  assign a_next  = grant ? req_a1  : req_a0;
  assign b_next  = grant ? req_b1  : req_b0;
  assign op_next = grant ? req_op1 : req_op0;

  always_comb begin
    op_ok = 1'b0;
    case (op_reg)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = 4'b0000;
    if (state_reg == EXEC) begin
      alu_a  = a_reg;
      alu_b  = b_reg;
      alu_op = op_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
      op_reg         <= 4'b0000;
      rsp_result_reg <= 32'd0;
      rsp_zero_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg          <= a_next;
        b_reg          <= b_next;
        op_reg         <= op_next;
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      // Unsupported ops report zero data so the ALU's undefined output never leaks.
      if (state_reg == EXEC) begin
        rsp_result_reg <= op_ok ? alu_result : 32'd0;
        rsp_zero_reg   <= alu_zero;
        rsp_err_reg    <= ~op_ok;
      end
    end
  end

  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_err    = rsp_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
  logic [3:0]  req_op0 = 0, req_op1 = 0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int id; int cyc;} acc_t;
  typedef struct {int id; logic [31:0] res; logic z; logic e; int cyc;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External ALU; unsupported ops return junk that the arbiter must suppress.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0011: alu_result = alu_a - alu_b;
      4'b0101: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, b, input logic [3:0] op);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd5: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5});
  endfunction

  // Reference model: one outstanding transaction, aged in cycles since accept.
  logic        m_out, m_last, m_own;
  int          m_age;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic        m_z, m_e;

  initial begin
    int g;
    logic [1:0] e_rdy, e_rv;
    m_out = 0; m_last = 1; m_own = 0; m_age = 0;
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_z = 0; m_e = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        m_out = 0; m_last = 1; m_age = 0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_z = 0; m_e = 0;
      end
      if (req_valid == 2'b11)   g = m_last ? 0 : 1;
      else if (req_valid[1])    g = 1;
      else                      g = 0;
      e_rdy = (reset_n && !m_out && req_valid[g]) ? 2'(1 << g) : 2'b00;
      e_rv  = (m_out && m_age >= 2) ? 2'(1 << m_own) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("busy", 32'(busy), 32'(m_out));
      chk("alu_a", alu_a, (m_out && m_age == 1) ? m_a : 32'd0);
      chk("alu_b", alu_b, (m_out && m_age == 1) ? m_b : 32'd0);
      chk("alu_op", 32'(alu_op), (m_out && m_age == 1) ? 32'(m_op) : 32'd0);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 32'(rsp_zero), 32'(m_z));
      chk("rsp_err", 32'(rsp_err), 32'(m_e));

      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_q.push_back('{id: i, cyc: cyc});
          $display("ACCEPT  id=%0d cycle=%0d", i, cyc);
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_q.push_back('{id: i, res: rsp_result, z: rsp_zero, e: rsp_err, cyc: cyc});
          $display("RESPOND id=%0d result=%h zero=%0b err=%0b cycle=%0d",
                   i, rsp_result, rsp_zero, rsp_err, cyc);
        end
      end

      if (reset_n) begin
        if (m_out) begin
          if (m_age >= 2) begin
            if (rsp_ready[m_own]) m_out = 0;
          end else begin
            m_age++;
            m_res = ref_res(m_a, m_b, m_op);
            m_z   = (m_a == m_b);
            m_e   = ref_err(m_op);
          end
        end else if (e_rdy != 2'b00) begin
          m_out = 1; m_age = 1; m_own = 1'(g); m_last = 1'(g);
          m_a  = g ? req_a1  : req_a0;
          m_b  = g ? req_b1  : req_b0;
          m_op = g ? req_op1 : req_op0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input int n0);
    int k = 0;
    while (acc_q.size() <= n0 && k < 30) begin step(1); k++; end
    if (acc_q.size() <= n0) begin
      checks++; errors++;
      $display("FAIL accept_timeout got none want accept (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_rsp(input int n0);
    int k = 0;
    while (rsp_q.size() <= n0 && k < 40) begin step(1); k++; end
    if (rsp_q.size() <= n0) begin
      checks++; errors++;
      $display("FAIL response_timeout got none want response (cycle %0d)", cyc);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a, b, input logic [3:0] op);
    if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
  endtask

  task automatic run_one(input int r, input logic [31:0] a, b, input logic [3:0] op,
                         input logic [31:0] x_res, input logic x_z, input logic x_e);
    int na, nr;
    na = acc_q.size();
    nr = rsp_q.size();
    set_req(r, a, b, op);
    req_valid = 2'(1 << r);
    wait_acc(na);
    req_valid = 2'b00;
    wait_rsp(nr);
    if (acc_q.size() > na && rsp_q.size() > nr) begin
      chk("lit_id", 32'(rsp_q[nr].id), 32'(r));
      chk("lit_result", rsp_q[nr].res, x_res);
      chk("lit_zero", 32'(rsp_q[nr].z), 32'(x_z));
      chk("lit_err", 32'(rsp_q[nr].e), 32'(x_e));
      chk("lit_latency", 32'(rsp_q[nr].cyc - acc_q[na].cyc), 32'd2);
    end
  endtask

  initial begin
    int na, nr;
    // Reset held with both requesters asking: nothing may be offered.
    req_valid = 2'b11;
    step(1);
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    step(1);
    reset_n = 1'b1;
    req_valid = 2'b00;
    step(1);

    run_one(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);
    run_one(1, 32'd3, 32'd3, 4'b0011, 32'd0, 1'b1, 1'b0);
    run_one(0, 32'd1, 32'd2, 4'b0100, 32'd0, 1'b0, 1'b1);
    run_one(1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b0, 1'b0);

    // Back-pressure; the non-owning rsp_ready bit and new requests must be ignored.
    rsp_ready = 2'b10;
    na = acc_q.size();
    nr = rsp_q.size();
    set_req(0, 32'h0000_00FF, 32'h0000_000F, 4'b0000);
    req_valid = 2'b01;
    wait_acc(na);
    req_valid = 2'b11;
    step(1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result, 32'h0000_000F);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    step(1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_rsp(nr);

    // Fresh reset, then both requesters contend continuously.
    step(2);
    reset_n = 1'b0;
    step(2);
    set_req(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0101);
    set_req(1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0101);
    req_valid = 2'b11;
    reset_n = 1'b1;
    na = acc_q.size();
    nr = rsp_q.size();
    for (int i = 0; i < 4; i++) wait_rsp(nr + i);
    req_valid = 2'b00;
    if (rsp_q.size() >= nr + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", 32'(rsp_q[nr + i].id), 32'(i % 2));
        chk("rr_result", rsp_q[nr + i].res, 32'hFFFF_FFFF);
      end
      chk("rr_spacing", 32'(acc_q[na + 1].cyc - acc_q[na].cyc), 32'd3);
    end
    step(6);

    // Reset while in EXEC drops the transaction; next tie goes to requester 0.
    set_req(0, 32'd9, 32'd4, 4'b0010);
    set_req(1, 32'd8, 32'd8, 4'b0001);
    na = acc_q.size();
    req_valid = 2'b01;
    wait_acc(na);
    req_valid = 2'b00;
    nr = rsp_q.size();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(6);
    chk("drop_no_rsp", 32'(rsp_q.size()), 32'(nr));
    chk("drop_busy", 32'(busy), 32'd0);
    na = acc_q.size();
    req_valid = 2'b11;
    wait_acc(na);
    req_valid = 2'b00;
    if (acc_q.size() > na) chk("post_rst_tie", 32'(acc_q[na].id), 32'd0);
    step(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
